m_div_unit: RTL and testbench
=============================

M_DIV_UNIT -- requirements
Module: m_div_unit

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: div_req_i  in  1  start request from EXE, sampled only in IDLE.
REQ-004 SHALL have ports: div_op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 SHALL have ports: rs1_data_i  in  32  dividend.
REQ-006 SHALL have ports: rs2_data_i  in  32  divisor.
REQ-007 SHALL have ports: rd_addr_i  in  5  destination register.
REQ-008 SHALL have ports: div_flush_i  in  1  abort, driven by the pipeline controller's LSU flush.
REQ-009 SHALL have ports: div_ack_o  out  1  one-cycle completion pulse to the forward/stall unit.
REQ-010 SHALL have ports: div_busy_o  out  1  high in CALC and DONE.
REQ-011 SHALL have ports: div_result_o  out  32  quotient or remainder, valid only while div_ack_o is high.
REQ-012 SHALL have ports: rd_addr_o  out  5  latched rd_addr_i.
REQ-013 SHALL have ports: rd_wr_req_o  out  1  equals div_ack_o and rd_addr_o != 0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 SHALL, in IDLE with div_req_i=1 and div_flush_i=0, latch the following and enter CALC with iteration counter=0:
- op and rd_addr;
- |rs1| and |rs2| (absolute values for signed ops, raw values for unsigned ops);
- sign of the quotient (rs1[31]^rs2[31]) and sign of the remainder (rs1[31]).
REQ-016 SHALL perform one restoring shift-subtract step per cycle in CALC, 32 steps, using a 33-bit partial remainder.
REQ-017 SHALL move CALC->DONE on the edge completing step 31, registering the sign-corrected result (negate quotient/remainder when the latched sign is set for DIV/REM).
REQ-018 SHALL assert div_ack_o only in DONE, for exactly one cycle, then return to IDLE.
REQ-019 SHALL give a latency of 33 cycles: request sampled at edge N, ack high in the cycle after edge N+32.
REQ-020 SHALL ignore div_req_i outside IDLE; no queuing.
REQ-021 SHALL, on div_flush_i=1 in any state, go to IDLE at the next edge with no ack; flush wins over a simultaneous div_req_i.
REQ-022 SHALL produce RISC-V-defined results without special-case logic:
- x/0: quotient 0xFFFFFFFF, remainder = rs1;
- signed 0x80000000/-1: quotient 0x80000000, remainder 0.
REQ-023 SHALL drive div_result_o to 0 when div_ack_o is low.

Reset
REQ-024 SHALL, on rst=1, immediately force state IDLE, counter 0, div_ack_o=0, div_busy_o=0, rd_wr_req_o=0, div_result_o=0, rd_addr_o=0, independent of clk.
REQ-025 SHALL abort an in-flight operation on reset mid-CALC and produce no ack after release.

Configuration
REQ-026 SHALL support macro DIV_EARLY_OUT_EN. When it is defined, a request with rs2=0 or |rs1|<|rs2| goes IDLE->DONE directly, acking in the cycle after edge N, with the results of REQ-022 (quotient 0, remainder rs1 when |rs1|<|rs2|).
REQ-027 SHALL, when DIV_EARLY_OUT_EN is undefined, take all operations the full 33-cycle path; results SHALL be identical in both builds.

Verification
REQ-028 SHALL cover DIVU 100/7, rd=5: ack after 33 cycles, result 14, rd_wr_req_o=1, rd_addr_o=5.
REQ-029 SHALL cover REM -7/2: result 0xFFFFFFFF (-1); DIV -7/2: result 0xFFFFFFFD (-3).
REQ-030 SHALL cover DIV 0x80000000/0xFFFFFFFF: result 0x80000000; DIVU 5/0: result 0xFFFFFFFF (1-cycle ack only with DIV_EARLY_OUT_EN).
REQ-031 SHALL cover div_flush_i pulsed at CALC step 10: no ack; a new DIVU 9/3 issued next cycle returns 3.
REQ-032 SHALL cover rst asserted mid-CALC between clock edges: outputs zero immediately; no ack after release.
REQ-033 SHALL cover div_req_i held high through DONE: exactly one ack per accepted request, and rd=0 gives rd_wr_req_o=0.

Source files
------------

// File: rtl/m_div_unit.sv
// m_div_unit: 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes, divided over 32 shift-subtract steps,
// and the selected quotient or remainder is sign-corrected on the last step.
// Optional macro DIV_EARLY_OUT_EN: a zero divisor or |rs1| < |rs2| is
// answered directly from IDLE with a single-cycle latency.
//
// state | meaning
// IDLE  | waiting for div_req_i; nothing latched is in flight
// CALC  | one restoring step per cycle, counter 0..31
// DONE  | result valid, div_ack_o high for this single cycle
module m_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic [1:0]  div_op_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        div_flush_i,
  output logic        div_ack_o,
  output logic        div_busy_o,
  output logic [31:0] div_result_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_wr_req_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] quo_q, quo_d;    // dividend shifts out the top, quotient bits in
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] res_q, res_d;

  logic        in_signed;
  logic [31:0] abs1, abs2;
  logic [32:0] rem_sh;
  logic        sub_ok;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] q_fin, r_fin, fin;

  // Operand magnitudes for the incoming request (signed ops use |x|).
  always_comb begin
    in_signed = ~div_op_i[0];
    abs1      = (in_signed && rs1_data_i[31]) ? -rs1_data_i : rs1_data_i;
    abs2      = (in_signed && rs2_data_i[31]) ? -rs2_data_i : rs2_data_i;
  end

  // One restoring step on a 33-bit partial remainder, plus the sign-corrected
  // final value assuming this is the last step.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    sub_ok = (rem_sh >= {1'b0, dvs_q});
    rem_nx = sub_ok ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
    quo_nx = {quo_q[30:0], sub_ok};
    q_fin  = (q_neg_q && !op_q[0]) ? -quo_nx : quo_nx;
    r_fin  = (r_neg_q && !op_q[0]) ? -rem_nx : rem_nx;
    fin    = op_q[1] ? r_fin : q_fin;
  end

`ifdef DIV_EARLY_OUT_EN
  logic        early;
  logic [31:0] early_res;

  // Trivial divisions: quotient is all ones (x/0) or zero, remainder is rs1.
  always_comb begin
    early     = (rs2_data_i == '0) || (abs1 < abs2);
    early_res = div_op_i[1] ? rs1_data_i :
                ((rs2_data_i == '0) ? '1 : '0);
  end
`endif

  // State, counter and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      res_q   <= res_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (div_req_i && !div_flush_i) begin
          op_d    = div_op_i;
          rd_d    = rd_addr_i;
          quo_d   = abs1;
          dvs_d   = abs2;
          rem_d   = '0;
          cnt_d   = '0;
          // A zero divisor must yield all ones even for signed DIV, so the
          // quotient sign only applies when the divisor is non-zero.
          q_neg_d = (rs1_data_i[31] ^ rs2_data_i[31]) & (|rs2_data_i);
          r_neg_d = rs1_data_i[31];
          state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (early) begin
            res_d   = early_res;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        if (div_flush_i) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_d   = fin;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign div_ack_o    = (state_q == S_DONE);
  assign div_busy_o   = (state_q == S_CALC) || (state_q == S_DONE);
  assign div_result_o = div_ack_o ? res_q : '0;
  assign rd_addr_o    = rd_q;
  assign rd_wr_req_o  = div_ack_o && (rd_q != '0);

endmodule

// File: tb/tb_m_div_unit.sv
module tb_m_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_req_i = 1'b0;
  logic [1:0]  div_op_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        div_flush_i = 1'b0;
  logic        div_ack_o;
  logic        div_busy_o;
  logic [31:0] div_result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wr_req_o;

  m_div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .div_op_i     (div_op_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .rd_addr_i    (rd_addr_i),
    .div_flush_i  (div_flush_i),
    .div_ack_o    (div_ack_o),
    .div_busy_o   (div_busy_o),
    .div_result_o (div_result_o),
    .rd_addr_o    (rd_addr_o),
    .rd_wr_req_o  (rd_wr_req_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectation state written by the driver, read by the compare process.
  int          exp_ack_cyc = -1;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_wr_rd = '0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic [4:0]  rd_prev = '0;
  logic [4:0]  rd_next = '0;
  int          rd_switch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result: ops 00 DIV, 01 DIVU, 10 REM, 11 REMU.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (op[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
    return op[1] ? r : q;
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma, mb;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    if (b == 32'd0 || ma < mb) return 1;
`else
    if (op == 2'b11 && a == 32'd0 && b == 32'd0) return 33;
`endif
    return 33;
  endfunction

  // Per-cycle comparison of every output against the expectation state.
  always @(negedge clk) begin
    logic       ea, eb;
    logic [4:0] erd;
    ea  = (cyc == exp_ack_cyc);
    eb  = (cyc >= busy_lo) && (cyc <= busy_hi);
    erd = (cyc >= rd_switch) ? rd_next : rd_prev;
    check("ack", 32'(div_ack_o), 32'(ea));
    check("busy", 32'(div_busy_o), 32'(eb));
    check("rd_addr", 32'(rd_addr_o), 32'(erd));
    if (ea) begin
      check("result", div_result_o, exp_res);
      check("rd_wr_req", 32'(rd_wr_req_o), 32'(exp_wr_rd != 5'd0));
    end else begin
      check("result_idle", div_result_o, 32'd0);
      check("rd_wr_idle", 32'(rd_wr_req_o), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int k, input int lat);
    exp_ack_cyc = k + lat;
    exp_res     = model(op, a, b);
    exp_wr_rd   = rd;
    busy_lo     = k + 1;
    busy_hi     = k + lat;
    rd_prev     = rd_next;
    rd_next     = rd;
    rd_switch   = k + 1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold);
    int k, lat, guard;
    k   = cyc;
    lat = lat_of(op, a, b);
    div_op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    div_req_i = 1'b1;
    expect_accept(op, a, b, rd, k, lat);
    tick();
    if (!hold) div_req_i = 1'b0;
    guard = 0;
    while (cyc < k + lat && guard < 100) begin
      tick();
      guard++;
    end
    div_req_i = 1'b0;
    tick();
  endtask

  task automatic flush_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int step);
    int k;
    k = cyc;
    div_op_i = 2'b01; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    div_req_i = 1'b1;
    expect_accept(2'b01, a, b, rd, k, 33);
    exp_ack_cyc = -1;
    busy_hi     = k + 1 + step;
    tick();
    div_req_i = 1'b0;
    while (cyc < k + 1 + step) tick();
    div_flush_i = 1'b1;
    tick();
    div_flush_i = 1'b0;
  endtask

  task automatic reset_mid_calc(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                                input int after);
    int k;
    k = cyc;
    div_op_i = 2'b01; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    div_req_i = 1'b1;
    expect_accept(2'b01, a, b, rd, k, 33);
    tick();
    div_req_i = 1'b0;
    while (cyc < k + after) tick();
    #1;
    rst = 1'b1;
    exp_ack_cyc = -1;
    busy_lo = 1; busy_hi = 0;
    rd_prev = '0; rd_next = '0; rd_switch = 0;
    #1;
    check("rst_ack", 32'(div_ack_o), 32'd0);
    check("rst_busy", 32'(div_busy_o), 32'd0);
    check("rst_result", div_result_o, 32'd0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check("rst_rd_wr", 32'(rd_wr_req_o), 32'd0);
    tick();
    tick();
    #1;
    rst = 1'b0;
    repeat (40) tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Hand-computed anchors for the reference model itself.
    check("model_divu_100_7", model(2'b01, 32'd100, 32'd7), 32'd14);
    check("model_rem_m7_2", model(2'b10, -32'd7, 32'd2), 32'hFFFF_FFFF);
    check("model_div_m7_2", model(2'b00, -32'd7, 32'd2), 32'hFFFF_FFFD);
    check("model_div_ovf", model(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_rem_ovf", model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    check("model_divu_5_0", model(2'b01, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("model_div_m5_0", model(2'b00, -32'd5, 32'd0), 32'hFFFF_FFFF);
    check("model_rem_m5_0", model(2'b10, -32'd5, 32'd0), -32'd5);

    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_op(2'b01, 32'd100, 32'd7, 5'd5, 1'b0);
    run_op(2'b10, -32'd7, 32'd2, 5'd3, 1'b0);
    run_op(2'b00, -32'd7, 32'd2, 5'd4, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b0);
    run_op(2'b01, 32'd5, 32'd0, 5'd7, 1'b0);
    run_op(2'b00, -32'd5, 32'd0, 5'd7, 1'b0);
    run_op(2'b10, -32'd5, 32'd0, 5'd7, 1'b0);
    run_op(2'b11, 32'd3, 32'd10, 5'd2, 1'b0);

    flush_op(32'd1000, 32'd3, 5'd8, 10);
    run_op(2'b01, 32'd9, 32'd3, 5'd9, 1'b0);

    // Flush beats a simultaneous request in IDLE: nothing is accepted.
    div_op_i = 2'b01; rs1_data_i = 32'd50; rs2_data_i = 32'd5; rd_addr_i = 5'd12;
    div_req_i = 1'b1; div_flush_i = 1'b1;
    tick();
    div_req_i = 1'b0; div_flush_i = 1'b0;
    repeat (3) tick();

    reset_mid_calc(32'd12345, 32'd7, 5'd10, 15);

    run_op(2'b01, 32'd100, 32'd7, 5'd0, 1'b1);
    run_op(2'b00, -32'd100, 32'd7, 5'd11, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 3) == 0));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
